// File: rtl/biu_constants_pkg.sv
// Bus-interface constants shared by the core data bus and its responders.
package biu_constants_pkg;

  // Transfer size code carried on dmem_size; only BYTE/HWORD/WORD are legal on a 32-bit bus.
  typedef enum logic [2:0] {
    BYTE  = 3'd0,
    HWORD = 3'd1,
    WORD  = 3'd2,
    DWORD = 3'd3,
    QWORD = 3'd4
  } biu_size_t;

endpackage

// File: rtl/dmem_resp_pkg.sv
// Types and decode helpers for the dmem TCM responder.
package dmem_resp_pkg;
  import biu_constants_pkg::*;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_resp_state_t;

  localparam int DMEM_MAX_LATENCY = 15;

  function automatic logic [3:0] be_gen(biu_size_t size, logic [1:0] a);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      BYTE:    be = 4'b0001 << a;
      HWORD:   be = 4'b0011 << a;
      WORD:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic is_misaligned(biu_size_t size, logic [1:0] a);
    logic m;
    m = 1'b0;
    case (size)
      HWORD:   m = a[0];
      WORD:    m = |a;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic size_supported(biu_size_t size);
    return (size == BYTE) || (size == HWORD) || (size == WORD);
  endfunction

endpackage

// File: rtl/dmem_resp_ram.sv
// Single-port byte-enabled scratchpad with registered read data (one cycle read latency).
module dmem_resp_ram #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [XLEN/8-1:0] be,
  input  logic [AW-1:0]     addr,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  // Read returns the pre-write contents when a write hits the same word.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < XLEN/8; i++) begin
        if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_tcm_responder.sv
// Data-memory bus slave backed by a TCM with programmable wait states.
// Optional write protection of the low RO_LIMIT bytes: define DMEM_RESP_WPROT_EN.
//
// state | meaning
// IDLE  | waiting for dmem_req; accepts and latches the request
// WAIT  | counting wait states down to zero
// RESP  | ack/err/misaligned/q presented for one cycle
module dmem_tcm_responder
  import biu_constants_pkg::*;
  import dmem_resp_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] MEM_BASE  = '0,
  parameter int              MEM_DEPTH = 1024,
  parameter int              LATENCY   = 1,
  parameter logic [XLEN-1:0] RO_LIMIT  = 'h100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dmem_req,
  input  logic [XLEN-1:0] dmem_adr,
  input  logic [XLEN-1:0] dmem_d,
  input  logic            dmem_we,
  input  biu_size_t       dmem_size,
  output logic [XLEN-1:0] dmem_q,
  output logic            dmem_ack,
  output logic            dmem_err,
  output logic            dmem_misaligned,
  output logic            dmem_page_fault
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [3:0] CNT_INIT = 4'((LATENCY > 1) ? (LATENCY - 2) : 0);
  localparam logic [XLEN:0] RANGE_LO = {1'b0, MEM_BASE};
  localparam logic [XLEN:0] RANGE_HI = {1'b0, MEM_BASE} + (XLEN+1)'(4 * MEM_DEPTH);
  localparam logic [XLEN:0] RO_END   = {1'b0, MEM_BASE} + {1'b0, RO_LIMIT};
`ifdef DMEM_RESP_WPROT_EN
  localparam logic WPROT_EN = 1'b1;
`else
  localparam logic WPROT_EN = 1'b0;
`endif

  dmem_resp_state_t state, state_nx;
  logic [3:0]       cnt, cnt_nx;
  logic             accept, fire;

  logic [XLEN-1:0]  adr_l, d_l;
  logic             we_l;
  biu_size_t        size_l;

  logic [XLEN-1:0]  cur_adr, cur_d;
  logic             cur_we;
  biu_size_t        cur_size;
  logic [XLEN:0]    adr_ext;
  logic             mis_c, size_bad, range_bad, wprot_bad, err_c;

  logic             rd_ok;
  logic             ram_en, ram_we;
  logic [3:0]       ram_be;
  logic [XLEN-1:0]  ram_rdata;

  // With LATENCY=1 the RESP-entry edge is also the accept edge, so decode from the bus directly.
  always_comb begin
    cur_adr  = adr_l;
    cur_d    = d_l;
    cur_we   = we_l;
    cur_size = size_l;
    if (state == IDLE) begin
      cur_adr  = dmem_adr;
      cur_d    = dmem_d;
      cur_we   = dmem_we;
      cur_size = dmem_size;
    end
  end

  always_comb begin
    adr_ext   = {1'b0, cur_adr};
    mis_c     = is_misaligned(cur_size, cur_adr[1:0]);
    size_bad  = !size_supported(cur_size);
    range_bad = (adr_ext < RANGE_LO) || (adr_ext >= RANGE_HI);
    wprot_bad = WPROT_EN && cur_we && (adr_ext < RO_END);
    err_c     = !mis_c && (size_bad || range_bad || wprot_bad);
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    fire     = 1'b0;
    case (state)
      IDLE: begin
        if (dmem_req) begin
          accept = 1'b1;
          if (LATENCY <= 1) begin
            state_nx = RESP;
            fire     = 1'b1;
          end else begin
            state_nx = WAIT;
            cnt_nx   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nx = RESP;
          fire     = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= 4'd0;
      adr_l           <= '0;
      d_l             <= '0;
      we_l            <= 1'b0;
      size_l          <= BYTE;
      dmem_ack        <= 1'b0;
      dmem_err        <= 1'b0;
      dmem_misaligned <= 1'b0;
      rd_ok           <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        adr_l  <= dmem_adr;
        d_l    <= dmem_d;
        we_l   <= dmem_we;
        size_l <= dmem_size;
      end
      dmem_ack        <= fire;
      dmem_err        <= fire && err_c;
      dmem_misaligned <= fire && mis_c;
      rd_ok           <= fire && !cur_we && !err_c && !mis_c;
    end
  end

  // rst gates the RAM so a write whose RESP-entry edge coincides with reset is dropped.
  assign ram_en = fire && !rst;
  assign ram_we = ram_en && cur_we && !err_c && !mis_c;
  assign ram_be = be_gen(cur_size, cur_adr[1:0]);

  dmem_resp_ram #(
    .XLEN  (XLEN),
    .DEPTH (MEM_DEPTH)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (cur_adr[AW+1:2]),
    .wdata (cur_d),
    .rdata (ram_rdata)
  );

  // rd_ok is a flop, so q is the RAM output register qualified by a registered flag.
  assign dmem_q          = rd_ok ? ram_rdata : '0;
  assign dmem_page_fault = 1'b0;

endmodule
